systolic_skew_stage: RTL

Parametrised diagonal skew/deskew buffer for the systolic-array datapath. Accepts one SA_LENGTH-wide vector per handshake, delays each lane by a lane-dependent number of advances (staircase skew at the array input, or mirrored deskew at the array output), and carries per-lane valid and tile-last markers alongside the data. When a tile ends it self-drains the staircase with zero bubbles, then signals completion. It replaces the fixed enable-driven skew register and sits between the operand buffers and the array edge, or between the array and the accumulators.

---
 rtl/systolic_skew_stage_if.sv | 50 +++++
 rtl/systolic_skew_stage.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/systolic_skew_stage_if.sv
// -----------------------------------------------------------------------------
// systolic_skew_stage_if
//
// Bundles the vector handshake and the skewed output bus of
// systolic_skew_stage.
//
// Handshake: a vector transfers on a rising CLK edge where IN_VALID and
// IN_READY are both high. The producer keeps IN_VALID, IN_LAST and IN_DATA
// stable until that edge. IN_READY never depends on IN_VALID. IN_LAST is
// only meaningful on the accepting cycle.
//
// Signals
//   IN_VALID    master->slave  input vector valid
//   IN_READY    slave->master  block accepts a vector this cycle
//   IN_LAST     master->slave  accepted vector closes the tile
//   IN_DATA     master->slave  input vector, lane 0 first
//   OUT_VALID   slave->master  per-lane element valid
//   OUT_LAST    slave->master  per-lane element belongs to the tile's last vector
//   OUT_DATA    slave->master  skewed output vector
//   BUSY        slave->master  FSM is streaming or draining
//   DRAIN_DONE  slave->master  one-cycle pulse once the staircase is empty
//   DBG_STATE   slave->master  raw FSM state (0 IDLE, 1 STREAM, 2 DRAIN)
// -----------------------------------------------------------------------------
interface systolic_skew_stage_if #(
    parameter int DATA_WIDTH = 8,
    parameter int SA_LENGTH  = 16
);
    logic                                 IN_VALID;
    logic                                 IN_READY;
    logic                                 IN_LAST;
    logic [0:SA_LENGTH-1][DATA_WIDTH-1:0] IN_DATA;
    logic [0:SA_LENGTH-1]                 OUT_VALID;
    logic [0:SA_LENGTH-1]                 OUT_LAST;
    logic [0:SA_LENGTH-1][DATA_WIDTH-1:0] OUT_DATA;
    logic                                 BUSY;
    logic                                 DRAIN_DONE;
    logic [1:0]                           DBG_STATE;

    modport master (
        output IN_VALID, IN_LAST, IN_DATA,
        input  IN_READY, OUT_VALID, OUT_LAST, OUT_DATA, BUSY, DRAIN_DONE,
               DBG_STATE
    );

    modport slave (
        input  IN_VALID, IN_LAST, IN_DATA,
        output IN_READY, OUT_VALID, OUT_LAST, OUT_DATA, BUSY, DRAIN_DONE,
               DBG_STATE
    );
endinterface

// File: rtl/systolic_skew_stage.sv
// -----------------------------------------------------------------------------
// systolic_skew_stage
//
// Diagonal skew/deskew buffer for the systolic-array edge. Lane i delays its
// element by d(i) advances: d(i) = i for skew (DESKEW=0), or
// d(i) = SA_LENGTH-1-i for deskew (DESKEW=1). Each element carries
// {valid, last, data}. When the tile's last vector is accepted, the block
// stops accepting input and self-advances SA_LENGTH-1 times. This pushes the
// staircase out. It then pulses DRAIN_DONE.
//
// Ports
//   CLK        rising-edge clock
//   ASYNC_RST  asynchronous active-low reset
//   SYNC_RST   synchronous active-high clear, same effect as ASYNC_RST
//   bus        systolic_skew_stage_if.slave (handshake, outputs, status)
// -----------------------------------------------------------------------------
module systolic_skew_stage #(
    parameter int DATA_WIDTH = 8,
    parameter int SA_LENGTH  = 16,
    parameter int DESKEW     = 0
) (
    input  logic                  CLK,
    input  logic                  ASYNC_RST,
    input  logic                  SYNC_RST,
    systolic_skew_stage_if.slave  bus
);

    localparam int CW = (SA_LENGTH > 1) ? $clog2(SA_LENGTH) : 1;
    localparam int EW = DATA_WIDTH + 2;   // {valid, last, data}

    // DRAIN lasts SA_LENGTH-1 cycles. The counter is loaded one short
    // because the cycle where it reads zero is itself a DRAIN cycle.
    localparam logic [CW-1:0] CNT_LOAD = CW'((SA_LENGTH > 1) ? SA_LENGTH - 2 : 0);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;

    logic in_drain;
    logic ready;
    logic accept;
    logic advance;

    always_comb begin
        in_drain = (state_q == ST_DRAIN);
        ready    = !SYNC_RST && !in_drain;
        accept   = bus.IN_VALID && ready;
        // A pending synchronous clear freezes the staircase for this cycle.
        advance  = !SYNC_RST && (accept || in_drain);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE, ST_STREAM: begin
                if (accept) begin
                    if (bus.IN_LAST) begin
                        if (SA_LENGTH > 1) begin
                            state_d = ST_DRAIN;
                            cnt_d   = CNT_LOAD;
                        end else begin
                            // With a single lane, nothing is left in flight.
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        state_d = ST_STREAM;
                    end
                end
            end
            ST_DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge ASYNC_RST) begin
        if (!ASYNC_RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else if (SYNC_RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign bus.IN_READY   = ready;
    assign bus.BUSY       = (state_q != ST_IDLE);
    assign bus.DRAIN_DONE = done_q;
    assign bus.DBG_STATE  = state_q;

    for (genvar i = 0; i < SA_LENGTH; i++) begin : g_lane
        localparam int D = (DESKEW != 0) ? (SA_LENGTH - 1 - i) : i;

        if (D == 0) begin : g_pass
            assign bus.OUT_DATA[i]  = bus.IN_DATA[i];
            assign bus.OUT_VALID[i] = accept;
            assign bus.OUT_LAST[i]  = accept & bus.IN_LAST;
        end else begin : g_chain
            logic [EW-1:0] chain_q [0:D-1];
            logic [EW-1:0] head_d;

            // During drain bubbles, accept is low. The head then loads
            // {0,0,0}, so stale input data never enters the staircase.
            assign head_d = {accept, accept & bus.IN_LAST,
                             accept ? bus.IN_DATA[i] : {DATA_WIDTH{1'b0}}};

            always_ff @(posedge CLK or negedge ASYNC_RST) begin
                if (!ASYNC_RST) begin
                    for (int k = 0; k < D; k++) chain_q[k] <= '0;
                end else if (SYNC_RST) begin
                    for (int k = 0; k < D; k++) chain_q[k] <= '0;
                end else if (advance) begin
                    chain_q[0] <= head_d;
                    for (int k = 1; k < D; k++) chain_q[k] <= chain_q[k-1];
                end
            end

            // Tail data stays visible between advances. Valid and last are
            // qualified so an element is presented exactly once.
            assign bus.OUT_DATA[i]  = chain_q[D-1][DATA_WIDTH-1:0];
            assign bus.OUT_VALID[i] = chain_q[D-1][EW-1] & advance;
            assign bus.OUT_LAST[i]  = chain_q[D-1][EW-2] & advance;
        end
    end

endmodule
